sched_csr_bridge: RTL and testbench

- Scheduler-side bridge between the warp scheduler and the CSR unit(s).
- Supplies the CSR unit(s) with a registered snapshot of the cycle counter, active warps and per-warp thread masks.
- Tracks the number of in-flight instructions per warp and answers almost-empty queries from NUM_CHANNELS CSR requesters through a round-robin arbiter.
- Keeps a per-warp lock bitmap that the scheduler sets and any channel can clear, with unlocks merged into a warp mask.

---
 rtl/sched_csr_bridge_if.sv | 47 ++++
 rtl/sched_csr_bridge.sv | 143 ++++++++++++++
 tb/tb_sched_csr_bridge.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sched_csr_bridge_if.sv
// Scheduler/CSR bridge bus: scheduler snapshot, issue/commit tracking, lock control and
// the per-channel almost-empty query and unlock requests.
interface sched_csr_bridge_if #(
    parameter int unsigned THREAD_CNT     = 4,
    parameter int unsigned WARP_CNT       = 4,
    parameter int unsigned WARP_CNT_WIDTH = 2,
    parameter int unsigned NUM_CHANNELS   = 2,
    parameter int unsigned CYCLE_BITS     = 44
);
    logic [WARP_CNT-1:0]                    sched_active_warps;
    logic [WARP_CNT*THREAD_CNT-1:0]         sched_thread_masks;
    logic [CYCLE_BITS-1:0]                  cycles;
    logic [WARP_CNT-1:0]                    active_warps;
    logic [WARP_CNT*THREAD_CNT-1:0]         thread_masks;
    logic                                   issue_valid;
    logic [WARP_CNT_WIDTH-1:0]              issue_wid;
    logic                                   commit_valid;
    logic [WARP_CNT_WIDTH-1:0]              commit_wid;
    logic                                   lock_valid;
    logic [WARP_CNT_WIDTH-1:0]              lock_wid;
    logic [WARP_CNT-1:0]                    locked_warps;
    logic [NUM_CHANNELS-1:0]                q_valid;
    logic [NUM_CHANNELS*WARP_CNT_WIDTH-1:0] q_wid;
    logic [NUM_CHANNELS-1:0]                q_ready;
    logic [NUM_CHANNELS-1:0]                rsp_valid;
    logic [NUM_CHANNELS-1:0]                rsp_alm_empty;
    logic [NUM_CHANNELS-1:0]                unlock_valid;
    logic [NUM_CHANNELS*WARP_CNT_WIDTH-1:0] unlock_wid;
    logic [WARP_CNT-1:0]                    unlock_mask;
    logic                                   cnt_err;

    modport master (
        output sched_active_warps, sched_thread_masks, issue_valid, issue_wid,
               commit_valid, commit_wid, lock_valid, lock_wid, q_valid, q_wid,
               unlock_valid, unlock_wid,
        input  cycles, active_warps, thread_masks, locked_warps, q_ready, rsp_valid,
               rsp_alm_empty, unlock_mask, cnt_err
    );

    modport slave (
        input  sched_active_warps, sched_thread_masks, issue_valid, issue_wid,
               commit_valid, commit_wid, lock_valid, lock_wid, q_valid, q_wid,
               unlock_valid, unlock_wid,
        output cycles, active_warps, thread_masks, locked_warps, q_ready, rsp_valid,
               rsp_alm_empty, unlock_mask, cnt_err
    );
endinterface

// File: rtl/sched_csr_bridge.sv
// Scheduler-side CSR bridge: registered scheduler snapshot, per-warp pending counters with
// round-robin almost-empty queries, and a warp lock bitmap with merged multi-channel unlocks.
module sched_csr_bridge #(
    parameter int unsigned THREAD_CNT       = 4,
    parameter int unsigned WARP_CNT         = 4,
    parameter int unsigned WARP_CNT_WIDTH   = 2,
    parameter int unsigned NUM_CHANNELS     = 2,
    parameter int unsigned PCNT_BITS        = 4,
    parameter int unsigned ALM_EMPTY_THRESH = 1,
    parameter int unsigned CYCLE_BITS       = 44
) (
    input  logic              clk,
    input  logic              reset,
    sched_csr_bridge_if.slave bus
);
    localparam int unsigned CH_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int unsigned WW   = WARP_CNT_WIDTH;
    localparam logic [WW:0]          WARP_LIMIT = (WW + 1)'(WARP_CNT);
    localparam logic [PCNT_BITS-1:0] THRESH     = PCNT_BITS'(ALM_EMPTY_THRESH);

    logic [CYCLE_BITS-1:0]          cycles_q;
    logic [WARP_CNT-1:0]            active_q;
    logic [WARP_CNT*THREAD_CNT-1:0] masks_q;
    logic [PCNT_BITS-1:0]           pend_q [WARP_CNT];
    logic [PCNT_BITS-1:0]           pend_d [WARP_CNT];
    logic                           err_q, err_d;
    logic [WARP_CNT-1:0]            locked_q, locked_d;
    logic [WARP_CNT-1:0]            unlock_mask_q, unlock_mask_d;
    logic [CH_W-1:0]                ptr_q, ptr_d;
    logic [NUM_CHANNELS-1:0]        rsp_valid_q, rsp_alm_q;

    logic [NUM_CHANNELS-1:0] grant;
    logic [CH_W-1:0]         grant_idx;
    logic [CH_W-1:0]         scan_idx;
    logic                    found;
    logic [WW-1:0]           sel_wid;
    logic                    alm_sel;
    logic [WARP_CNT-1:0]     issue_hit, commit_hit, lock_hit, unlock_hit;

    // Round-robin: scan channels starting at the pointer, first requester wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        scan_idx  = '0;
        found     = 1'b0;
        for (int k = 0; k < NUM_CHANNELS; k++) begin
            scan_idx = CH_W'((int'(ptr_q) + k) % int'(NUM_CHANNELS));
            if (!found && bus.q_valid[scan_idx]) begin
                found           = 1'b1;
                grant[scan_idx] = 1'b1;
                grant_idx       = scan_idx;
            end
        end
        ptr_d = ptr_q;
        if (found) begin
            ptr_d = (grant_idx == CH_W'(NUM_CHANNELS - 1)) ? '0 : grant_idx + CH_W'(1);
        end
    end

    // Answer uses the count before this cycle's issue/commit update.
    always_comb begin
        sel_wid = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (grant[c]) sel_wid = bus.q_wid[c*WW +: WW];
        end
        alm_sel = 1'b1;
        if ({1'b0, sel_wid} < WARP_LIMIT) alm_sel = (pend_q[sel_wid] <= THRESH);
    end

    always_comb begin
        issue_hit  = '0;
        commit_hit = '0;
        lock_hit   = '0;
        unlock_hit = '0;
        for (int w = 0; w < WARP_CNT; w++) begin
            issue_hit[w]  = bus.issue_valid  && (bus.issue_wid  == WW'(w));
            commit_hit[w] = bus.commit_valid && (bus.commit_wid == WW'(w));
            lock_hit[w]   = bus.lock_valid   && (bus.lock_wid   == WW'(w));
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                if (bus.unlock_valid[c] && (bus.unlock_wid[c*WW +: WW] == WW'(w))) begin
                    unlock_hit[w] = 1'b1;
                end
            end
        end
    end

    // Saturating counters; simultaneous issue and commit on one warp cancel out.
    always_comb begin
        err_d = err_q;
        for (int w = 0; w < WARP_CNT; w++) begin
            pend_d[w] = pend_q[w];
            if (issue_hit[w] && !commit_hit[w]) begin
                if (&pend_q[w]) err_d = 1'b1;
                else            pend_d[w] = pend_q[w] + PCNT_BITS'(1);
            end else if (commit_hit[w] && !issue_hit[w]) begin
                if (pend_q[w] == '0) err_d = 1'b1;
                else                 pend_d[w] = pend_q[w] - PCNT_BITS'(1);
            end
        end
    end

    // Clear before set, so a same-cycle lock wins but the unlock is still reported.
    always_comb begin
        unlock_mask_d = locked_q & unlock_hit;
        locked_d      = (locked_q & ~unlock_hit) | lock_hit;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycles_q      <= '0;
            active_q      <= '0;
            masks_q       <= '0;
            err_q         <= 1'b0;
            locked_q      <= '0;
            unlock_mask_q <= '0;
            ptr_q         <= '0;
            rsp_valid_q   <= '0;
            rsp_alm_q     <= '0;
            for (int w = 0; w < WARP_CNT; w++) pend_q[w] <= '0;
        end else begin
            cycles_q      <= cycles_q + CYCLE_BITS'(1);
            active_q      <= bus.sched_active_warps;
            masks_q       <= bus.sched_thread_masks;
            err_q         <= err_d;
            locked_q      <= locked_d;
            unlock_mask_q <= unlock_mask_d;
            ptr_q         <= ptr_d;
            rsp_valid_q   <= grant;
            rsp_alm_q     <= grant & {NUM_CHANNELS{alm_sel}};
            for (int w = 0; w < WARP_CNT; w++) pend_q[w] <= pend_d[w];
        end
    end

    assign bus.q_ready       = grant;
    assign bus.cycles        = cycles_q;
    assign bus.active_warps  = active_q;
    assign bus.thread_masks  = masks_q;
    assign bus.locked_warps  = locked_q;
    assign bus.unlock_mask   = unlock_mask_q;
    assign bus.rsp_valid     = rsp_valid_q;
    assign bus.rsp_alm_empty = rsp_alm_q;
    assign bus.cnt_err       = err_q;
endmodule

// File: tb/tb_sched_csr_bridge.sv
// Self-checking bench for sched_csr_bridge: directed vector table, hand-written corner
// sequences and randomized traffic compared against a behavioural model.
module tb_sched_csr_bridge;
    localparam int unsigned TC = 4, WC = 4, WW = 2, NC = 2, PB = 4, TH = 1, CB = 8;
    localparam int PMAX = (1 << PB) - 1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    sched_csr_bridge_if #(.THREAD_CNT(TC), .WARP_CNT(WC), .WARP_CNT_WIDTH(WW),
                          .NUM_CHANNELS(NC), .CYCLE_BITS(CB)) bus ();

    sched_csr_bridge #(.THREAD_CNT(TC), .WARP_CNT(WC), .WARP_CNT_WIDTH(WW),
                       .NUM_CHANNELS(NC), .PCNT_BITS(PB), .ALM_EMPTY_THRESH(TH),
                       .CYCLE_BITS(CB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    int          pend [WC];
    bit          m_err;
    bit [WC-1:0] m_locked, m_um, m_act;
    bit [WC*TC-1:0] m_tm;
    bit [NC-1:0] m_rv, m_ra;
    int          m_ptr, m_cyc, last_grant;

    typedef struct {
        logic iv; logic [1:0] iw; logic cv; logic [1:0] cw; logic lv; logic [1:0] lw;
        logic [1:0] qv; logic [3:0] qw; logic [1:0] uv; logic [3:0] uw;
        logic [1:0] e_qr, e_rv, e_ra; logic [3:0] e_lk, e_um; logic e_er;
    } vec_t;
    vec_t vecs [22];

    function automatic vec_t mk(input logic iv, input logic [1:0] iw, input logic cv,
                                input logic [1:0] cw, input logic lv, input logic [1:0] lw,
                                input logic [1:0] qv, input logic [3:0] qw,
                                input logic [1:0] uv, input logic [3:0] uw,
                                input logic [1:0] e_qr, input logic [1:0] e_rv,
                                input logic [1:0] e_ra, input logic [3:0] e_lk,
                                input logic [3:0] e_um, input logic e_er);
        vec_t v;
        v.iv = iv; v.iw = iw; v.cv = cv; v.cw = cw; v.lv = lv; v.lw = lw;
        v.qv = qv; v.qw = qw; v.uv = uv; v.uw = uw;
        v.e_qr = e_qr; v.e_rv = e_rv; v.e_ra = e_ra; v.e_lk = e_lk; v.e_um = e_um;
        v.e_er = e_er;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int w = 0; w < WC; w++) pend[w] = 0;
        m_err = 0; m_locked = '0; m_um = '0; m_act = '0; m_tm = '0;
        m_rv = '0; m_ra = '0; m_ptr = 0; m_cyc = 0; last_grant = -1;
    endtask

    function automatic int model_grant();
        for (int k = 0; k < NC; k++) begin
            if (bus.q_valid[(m_ptr + k) % NC]) return (m_ptr + k) % NC;
        end
        return -1;
    endfunction

    task automatic model_update(input int g);
        int wid;
        bit [WC-1:0] uset;
        m_rv = '0; m_ra = '0;
        if (g >= 0) begin
            wid = int'(bus.q_wid[g*WW +: WW]);
            m_rv[g] = 1'b1;
            m_ra[g] = (wid >= WC) ? 1'b1 : (pend[wid] <= TH);
            m_ptr = (g + 1) % NC;
        end
        if (bus.issue_valid && bus.commit_valid && bus.issue_wid == bus.commit_wid) begin
        end else begin
            if (bus.issue_valid) begin
                if (pend[bus.issue_wid] == PMAX) m_err = 1;
                else pend[bus.issue_wid]++;
            end
            if (bus.commit_valid) begin
                if (pend[bus.commit_wid] == 0) m_err = 1;
                else pend[bus.commit_wid]--;
            end
        end
        uset = '0;
        for (int c = 0; c < NC; c++) begin
            if (bus.unlock_valid[c] && int'(bus.unlock_wid[c*WW +: WW]) < WC)
                uset[bus.unlock_wid[c*WW +: WW]] = 1'b1;
        end
        m_um = m_locked & uset;
        m_locked = m_locked & ~uset;
        if (bus.lock_valid && int'(bus.lock_wid) < WC) m_locked[bus.lock_wid] = 1'b1;
        m_cyc = (m_cyc + 1) % (1 << CB);
        m_act = bus.sched_active_warps;
        m_tm = bus.sched_thread_masks;
        last_grant = g;
    endtask

    task automatic check_outputs();
        chk("cycles", bus.cycles, m_cyc);
        chk("active_warps", bus.active_warps, m_act);
        chk("thread_masks", bus.thread_masks, m_tm);
        chk("locked_warps", bus.locked_warps, m_locked);
        chk("rsp_valid", bus.rsp_valid, m_rv);
        chk("rsp_alm_empty", bus.rsp_alm_empty, m_ra);
        chk("unlock_mask", bus.unlock_mask, m_um);
        chk("cnt_err", bus.cnt_err, m_err);
    endtask

    task automatic drive_idle();
        bus.sched_active_warps = '0; bus.sched_thread_masks = '0;
        bus.issue_valid = 0; bus.issue_wid = '0; bus.commit_valid = 0; bus.commit_wid = '0;
        bus.lock_valid = 0; bus.lock_wid = '0; bus.q_valid = '0; bus.q_wid = '0;
        bus.unlock_valid = '0; bus.unlock_wid = '0;
    endtask

    // Inputs are applied at the negedge; q_ready is checked, then the edge is taken.
    task automatic step();
        int g;
        logic [NC-1:0] eqr;
        #1;
        g = model_grant();
        eqr = '0;
        if (g >= 0) eqr[g] = 1'b1;
        chk("q_ready", bus.q_ready, eqr);
        model_update(g);
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic query(input int ch, input int wid);
        drive_idle();
        bus.q_valid[ch] = 1'b1;
        bus.q_wid[ch*WW +: WW] = WW'(wid);
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0]  = mk(1,2,0,0,0,0, 2'b00,4'h0, 2'b00,4'h0, 2'b00,2'b00,2'b00,4'h0,4'h0,0);
        vecs[1]  = vecs[0];
        vecs[2]  = vecs[0];
        vecs[3]  = mk(0,0,0,0,0,0, 2'b01,4'h2, 2'b00,4'h0, 2'b01,2'b01,2'b00,4'h0,4'h0,0);
        vecs[4]  = mk(0,0,1,2,0,0, 2'b00,4'h0, 2'b00,4'h0, 2'b00,2'b00,2'b00,4'h0,4'h0,0);
        vecs[5]  = vecs[4];
        vecs[6]  = mk(0,0,0,0,0,0, 2'b01,4'h2, 2'b00,4'h0, 2'b01,2'b01,2'b01,4'h0,4'h0,0);
        vecs[7]  = mk(0,0,0,0,0,0, 2'b11,4'hA, 2'b00,4'h0, 2'b10,2'b10,2'b10,4'h0,4'h0,0);
        vecs[8]  = mk(0,0,0,0,0,0, 2'b11,4'hA, 2'b00,4'h0, 2'b01,2'b01,2'b01,4'h0,4'h0,0);
        vecs[9]  = vecs[7];
        vecs[10] = vecs[8];
        vecs[11] = mk(1,1,1,1,0,0, 2'b00,4'h0, 2'b00,4'h0, 2'b00,2'b00,2'b00,4'h0,4'h0,0);
        vecs[12] = mk(0,0,0,0,0,0, 2'b10,4'h4, 2'b00,4'h0, 2'b10,2'b10,2'b10,4'h0,4'h0,0);
        vecs[13] = mk(0,0,1,0,0,0, 2'b00,4'h0, 2'b00,4'h0, 2'b00,2'b00,2'b00,4'h0,4'h0,1);
        vecs[14] = mk(0,0,0,0,0,0, 2'b01,4'h0, 2'b00,4'h0, 2'b01,2'b01,2'b01,4'h0,4'h0,1);
        vecs[15] = mk(0,0,0,0,1,1, 2'b00,4'h0, 2'b00,4'h0, 2'b00,2'b00,2'b00,4'h2,4'h0,1);
        vecs[16] = mk(0,0,0,0,1,3, 2'b00,4'h0, 2'b00,4'h0, 2'b00,2'b00,2'b00,4'hA,4'h0,1);
        vecs[17] = mk(0,0,0,0,0,0, 2'b00,4'h0, 2'b11,4'hD, 2'b00,2'b00,2'b00,4'h0,4'hA,1);
        vecs[18] = mk(0,0,0,0,0,0, 2'b00,4'h0, 2'b01,4'h2, 2'b00,2'b00,2'b00,4'h0,4'h0,1);
        vecs[19] = mk(0,0,0,0,1,2, 2'b00,4'h0, 2'b00,4'h0, 2'b00,2'b00,2'b00,4'h4,4'h0,1);
        vecs[20] = mk(0,0,0,0,1,2, 2'b00,4'h0, 2'b10,4'h8, 2'b00,2'b00,2'b00,4'h4,4'h4,1);
        vecs[21] = mk(0,0,0,0,0,0, 2'b00,4'h0, 2'b00,4'h0, 2'b00,2'b00,2'b00,4'h4,4'h0,1);

        // Reset state and free-running cycle count
        drive_idle();
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check_outputs();
        for (int n = 0; n < 19; n++) step();
        chk("cycles_after_19", bus.cycles, 19);

        // Directed vector table
        foreach (vecs[i]) begin
            bus.sched_active_warps = WC'($urandom);
            bus.sched_thread_masks = (WC*TC)'($urandom);
            bus.issue_valid = vecs[i].iv;  bus.issue_wid = vecs[i].iw;
            bus.commit_valid = vecs[i].cv; bus.commit_wid = vecs[i].cw;
            bus.lock_valid = vecs[i].lv;   bus.lock_wid = vecs[i].lw;
            bus.q_valid = vecs[i].qv;      bus.q_wid = vecs[i].qw;
            bus.unlock_valid = vecs[i].uv; bus.unlock_wid = vecs[i].uw;
            #1 chk($sformatf("vec%0d_q_ready", i), bus.q_ready, vecs[i].e_qr);
            step();
            chk($sformatf("vec%0d_rsp_valid", i), bus.rsp_valid, vecs[i].e_rv);
            chk($sformatf("vec%0d_rsp_alm", i), bus.rsp_alm_empty, vecs[i].e_ra);
            chk($sformatf("vec%0d_locked", i), bus.locked_warps, vecs[i].e_lk);
            chk($sformatf("vec%0d_unlock_mask", i), bus.unlock_mask, vecs[i].e_um);
            chk($sformatf("vec%0d_cnt_err", i), bus.cnt_err, vecs[i].e_er);
        end

        // Reset during a granted query: the response must never appear
        drive_idle();
        bus.q_valid = 2'b01;
        #1 chk("abort_q_ready", bus.q_ready, 2'b01);
        #2 reset = 1'b1;
        model_reset();
        @(posedge clk);
        #1 chk("abort_rsp_in_reset", bus.rsp_valid, 2'b00);
        @(negedge clk);
        drive_idle();
        reset = 1'b0;
        check_outputs();
        step();
        chk("abort_rsp_after", bus.rsp_valid, 2'b00);
        query(0, 2);
        chk("post_reset_alm", bus.rsp_alm_empty, 2'b01);

        // Saturation at all-ones: count must hold, not wrap
        for (int n = 0; n < PMAX + 1; n++) begin
            drive_idle(); bus.issue_valid = 1; bus.issue_wid = 2'd3; step();
        end
        chk("overflow_err", bus.cnt_err, 1'b1);
        for (int n = 0; n < PMAX - 1; n++) begin
            drive_idle(); bus.commit_valid = 1; bus.commit_wid = 2'd3; step();
        end
        query(1, 3);
        chk("overflow_hold_alm", bus.rsp_alm_empty, 2'b10);

        // Randomized traffic; requesters hold their query until granted
        reset = 1'b1;
        model_reset();
        drive_idle();
        @(negedge clk);
        reset = 1'b0;
        check_outputs();
        for (int n = 0; n < 600; n++) begin
            for (int c = 0; c < NC; c++) begin
                if (!(bus.q_valid[c] && last_grant != c)) begin
                    bus.q_valid[c] = ($urandom_range(0, 2) != 0);
                    bus.q_wid[c*WW +: WW] = WW'($urandom_range(0, WC - 1));
                end
                bus.unlock_valid[c] = ($urandom_range(0, 3) == 0);
                bus.unlock_wid[c*WW +: WW] = WW'($urandom_range(0, WC - 1));
            end
            bus.sched_active_warps = WC'($urandom);
            bus.sched_thread_masks = (WC*TC)'($urandom);
            bus.issue_valid = ($urandom_range(0, 1) == 1);
            bus.issue_wid = WW'($urandom_range(0, WC - 1));
            bus.commit_valid = ($urandom_range(0, 2) == 0);
            bus.commit_wid = WW'($urandom_range(0, WC - 1));
            bus.lock_valid = ($urandom_range(0, 3) == 0);
            bus.lock_wid = WW'($urandom_range(0, WC - 1));
            step();
        end

        // Cycle counter wrap from all-ones
        drive_idle();
        for (int n = 0; n < 300 && m_cyc != (1 << CB) - 1; n++) step();
        chk("cycles_all_ones", bus.cycles, (1 << CB) - 1);
        step();
        chk("cycles_wrap", bus.cycles, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
